// File: rtl/parity_serial_pkg.sv
// rtl/parity_serial_pkg.sv - shared state encoding and sizing helpers for the parity serial transmitter
package parity_serial_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_e;

    // Width of a counter that must hold values 0..clks (CLKS_PER_BIT=1 still gets one bit)
    function automatic int cnt_width(input int clks);
        return $clog2(clks + 1);
    endfunction

endpackage

// File: rtl/parity_serial_tx_baud_tick_gen.sv
// rtl/parity_serial_tx_baud_tick_gen.sv - bit period counter pulsing tick on the last cycle of each bit
module baud_tick_gen
    import parity_serial_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic tick
);

    localparam int CW = cnt_width(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt;

    // With CLKS_PER_BIT=1 LAST is 0, so tick is permanently high and the counter never leaves 0
    assign tick = (cnt == LAST);

    // Count through one bit period, restarting on each tick and held at zero while idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/parity_serial_tx.sv
// rtl/parity_serial_tx.sv - frames a parallel word as start, LSB-first data, parity and stop bits
module parity_serial_tx
    import parity_serial_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4,
    parameter int DATA_W       = 8,
    parameter int PARITY_ODD   = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              tx_out,
    output logic              busy
);

    localparam int BW = cnt_width(DATA_W);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);
    localparam logic ODD = (PARITY_ODD != 0);

    tx_state_e         state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [BW-1:0]     bit_q, bit_d;
    logic              par_q, par_d;
    logic              out_q, out_d;
    logic              tick;

    baud_tick_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tick (
        .clk  (clk),
        .rst_n(rst_n),
        .clear(state_q == IDLE),
        .tick (tick)
    );

    assign tx_ready = (state_q == IDLE);
    assign busy     = (state_q != IDLE);
    assign tx_out   = out_q;

    // Next-state, datapath and next line level; the line level is derived from the next state
    // so that tx_out can be registered yet still change on the same edge as the state
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        bit_d   = bit_q;
        par_d   = par_q;
        out_d   = 1'b1;
        case (state_q)
            IDLE: begin
                if (tx_valid) begin
                    state_d = START;
                    shift_d = tx_data;
                    par_d   = (^tx_data) ^ ODD;
                    bit_d   = '0;
                end
            end
            START: begin
                if (tick) state_d = DATA;
            end
            DATA: begin
                if (tick) begin
                    if (bit_q == BIT_LAST) begin
                        state_d = PARITY;
                        bit_d   = '0;
                    end else begin
                        bit_d   = bit_q + BW'(1);
                        shift_d = shift_q >> 1;
                    end
                end
            end
            PARITY: begin
                if (tick) state_d = STOP;
            end
            STOP: begin
                if (tick) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        case (state_d)
            START:   out_d = 1'b0;
            DATA:    out_d = shift_d[0];
            PARITY:  out_d = par_d;
            default: out_d = 1'b1;
        endcase
    end

    // State and datapath registers; reset abandons any frame and returns the line high
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            shift_q <= '0;
            bit_q   <= '0;
            par_q   <= 1'b0;
            out_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            bit_q   <= bit_d;
            par_q   <= par_d;
            out_q   <= out_d;
        end
    end

endmodule

// File: tb/tb_parity_serial_tx.sv
// tb/tb_parity_serial_tx.sv - self-checking bench for parity_serial_tx against a frame-level model
module tb_parity_serial_tx;

    logic       clk;
    logic       rst_n;
    logic [7:0] tx_data;
    logic [2:0] valid_v;
    logic [2:0] ready_v;
    logic [2:0] out_v;
    logic [2:0] busy_v;

    int vectors;
    int miscompares;

    // Instance 0: 4 clocks/bit even parity, 1: 4 clocks/bit odd parity, 2: 1 clock/bit even parity
    parity_serial_tx #(.CLKS_PER_BIT(4), .DATA_W(8), .PARITY_ODD(0)) dut (
        .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(valid_v[0]),
        .tx_ready(ready_v[0]), .tx_out(out_v[0]), .busy(busy_v[0]));

    parity_serial_tx #(.CLKS_PER_BIT(4), .DATA_W(8), .PARITY_ODD(1)) dut_odd (
        .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(valid_v[1]),
        .tx_ready(ready_v[1]), .tx_out(out_v[1]), .busy(busy_v[1]));

    parity_serial_tx #(.CLKS_PER_BIT(1), .DATA_W(8), .PARITY_ODD(0)) dut_fast (
        .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(valid_v[2]),
        .tx_ready(ready_v[2]), .tx_out(out_v[2]), .busy(busy_v[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int clks_of(input int sel);
        return (sel == 2) ? 1 : 4;
    endfunction

    // Frame as a list of line levels, one per bit slot: start, data LSB first, parity, stop
    function automatic logic model_bit(input logic [7:0] d, input int odd, input int slot);
        logic p;
        p = 1'b0;
        for (int i = 0; i < 8; i++) p = p ^ d[i];
        if (odd != 0) p = ~p;
        if (slot == 0) return 1'b0;
        if (slot <= 8) return d[slot-1];
        if (slot == 9) return p;
        return 1'b1;
    endfunction

    // Sends one word on instance sel and checks every cycle of the frame plus the idle cycle after it
    task automatic test_frame(input int sel, input logic [7:0] d, output logic par_obs);
        int c;
        int len;
        logic [2:0] exp_v;
        logic [2:0] got_v;
        c = clks_of(sel);
        len = 11 * c;
        par_obs = 1'bx;
        @(negedge clk);
        vectors++;
        if (ready_v[sel] !== 1'b1) begin
            miscompares++;
            $display("FAIL frame_ready_before sel=%0d got=%b want=1", sel, ready_v[sel]);
        end
        tx_data = d;
        valid_v[sel] = 1'b1;
        @(posedge clk);
        #1;
        valid_v[sel] = 1'b0;
        tx_data = 8'($urandom);
        for (int k = 0; k < len; k++) begin
            @(negedge clk);
            exp_v = {model_bit(d, sel == 1 ? 1 : 0, k / c), 1'b1, 1'b0};
            got_v = {out_v[sel], busy_v[sel], ready_v[sel]};
            if (k / c == 9 && k % c == c / 2) par_obs = out_v[sel];
            vectors++;
            if (got_v !== exp_v) begin
                miscompares++;
                $display("FAIL frame sel=%0d data=%h cycle=%0d out/busy/ready got=%b want=%b",
                         sel, d, k, got_v, exp_v);
            end
        end
        @(negedge clk);
        got_v = {out_v[sel], busy_v[sel], ready_v[sel]};
        vectors++;
        if (got_v !== 3'b101) begin
            miscompares++;
            $display("FAIL frame_end sel=%0d data=%h out/busy/ready got=%b want=101", sel, d, got_v);
        end
    endtask

    task automatic test_reset();
        logic [8:0] got;
        rst_n = 1'b0;
        valid_v = '0;
        tx_data = '0;
        repeat (3) @(negedge clk);
        got = {out_v, busy_v, ready_v};
        vectors++;
        if (got !== 9'b111_000_111) begin
            miscompares++;
            $display("FAIL reset_values got=%b want=111000111", got);
        end
        rst_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            got = {out_v, busy_v, ready_v};
            vectors++;
            if (got !== 9'b111_000_111) begin
                miscompares++;
                $display("FAIL idle_after_reset cycle=%0d got=%b want=111000111", k, got);
            end
        end
    endtask

    task automatic test_basic();
        logic p;
        test_frame(0, 8'hA5, p);
        test_frame(2, 8'hFF, p);
    endtask

    task automatic test_parity();
        logic p;
        test_frame(0, 8'h07, p);
        vectors++;
        if (p !== 1'b1) begin
            miscompares++;
            $display("FAIL parity_even_07 got=%b want=1", p);
        end
        test_frame(1, 8'h07, p);
        vectors++;
        if (p !== 1'b0) begin
            miscompares++;
            $display("FAIL parity_odd_07 got=%b want=0", p);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] words [2];
        logic [2:0] exp_v;
        logic [2:0] got_v;
        words[0] = 8'h3C;
        words[1] = 8'hC3;
        @(negedge clk);
        tx_data = words[0];
        valid_v[0] = 1'b1;
        @(posedge clk);
        #1;
        tx_data = words[1];
        for (int f = 0; f < 2; f++) begin
            for (int k = 0; k < 44; k++) begin
                @(negedge clk);
                exp_v = {model_bit(words[f], 0, k / 4), 1'b1, 1'b0};
                got_v = {out_v[0], busy_v[0], ready_v[0]};
                vectors++;
                if (got_v !== exp_v) begin
                    miscompares++;
                    $display("FAIL b2b frame=%0d cycle=%0d out/busy/ready got=%b want=%b",
                             f, k, got_v, exp_v);
                end
            end
            @(negedge clk);
            got_v = {out_v[0], busy_v[0], ready_v[0]};
            vectors++;
            if (got_v !== 3'b101) begin
                miscompares++;
                $display("FAIL b2b_gap frame=%0d out/busy/ready got=%b want=101", f, got_v);
            end
            if (f == 0) begin
                @(posedge clk);
                #1;
                valid_v[0] = 1'b0;
                tx_data = 8'($urandom);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        logic p;
        logic [2:0] got_v;
        @(negedge clk);
        tx_data = 8'($urandom);
        valid_v[0] = 1'b1;
        @(posedge clk);
        #1;
        valid_v[0] = 1'b0;
        repeat (17) @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            got_v = {out_v[0], busy_v[0], ready_v[0]};
            vectors++;
            if (got_v !== 3'b101) begin
                miscompares++;
                $display("FAIL reset_mid_frame step=%0d out/busy/ready got=%b want=101", k, got_v);
            end
            @(negedge clk);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        got_v = {out_v[0], busy_v[0], ready_v[0]};
        vectors++;
        if (got_v !== 3'b101) begin
            miscompares++;
            $display("FAIL after_reset_no_resume out/busy/ready got=%b want=101", got_v);
        end
        test_frame(0, 8'h5A, p);
    endtask

    task automatic test_random();
        logic p;
        int sel;
        for (int n = 0; n < 12; n++) begin
            sel = $urandom_range(0, 2);
            test_frame(sel, 8'($urandom), p);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        rst_n = 1'b0;
        valid_v = '0;
        tx_data = '0;
        test_reset();
        test_basic();
        test_parity();
        test_back_to_back();
        test_reset_mid_frame();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
